// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_ctrl
//  Purpose  : Stall/flush sequencer for the 5-stage pipeline: register
//             enables, IF/ID flush, ID/EX bubble, halt drain, stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int CNTL_DELAY = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_memHzd,
    input  logic             id_branchHzd,
    input  logic             id_cntlHzd,
    input  logic             id_hlt,
    input  logic             wb_hlt,
    input  logic             icache_rdy,
    input  logic             dcache_req,
    input  logic             dcache_rdy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0]       c_st_run   = 2'd0;
    localparam logic [1:0]       c_st_wait  = 2'd1;
    localparam logic [1:0]       c_st_drain = 2'd2;
    localparam logic [1:0]       c_st_halt  = 2'd3;
    localparam logic [2:0]       c_cnt_init = 3'(CNTL_DELAY - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_freeze;

    assign w_freeze     = dcache_req && !dcache_rdy;
    assign halted       = r_halted;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_st_run;
            r_cnt          <= 3'd0;
            r_halted       <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_halted <= (w_state_nxt == c_st_halt);
            if (r_state != c_st_halt && !pc_en && r_stall_cycles != c_cnt_max)
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (r_state == c_st_halt || w_freeze) begin
            // Frozen or halted: nothing moves, state and countdown hold.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            case (r_state)
                c_st_run: begin
                    if (id_memHzd || id_branchHzd) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_cntlHzd) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                        if (id_hlt) begin
                            w_state_nxt = c_st_drain;
                        end else begin
                            w_state_nxt = c_st_wait;
                            w_cnt_nxt   = c_cnt_init;
                        end
                    end else if (!icache_rdy) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
                c_st_wait: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (r_cnt != 3'd0) begin
                        pc_en     = 1'b0;
                        w_cnt_nxt = r_cnt - 3'd1;
                    end else if (icache_rdy) begin
                        w_state_nxt = c_st_run;
                    end else begin
                        pc_en = 1'b0;
                    end
                end
                default: begin
                    pc_en       = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
            endcase
            // A hlt reaching WB ends everything, wherever we are.
            if (wb_hlt) begin
                w_state_nxt = c_st_halt;
                w_cnt_nxt   = 3'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_stall_ctrl
//  Purpose  : Randomized and directed scoreboard bench for pipeline_stall_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

    localparam int CNTL_DELAY = 2;
    localparam int CNT_W      = 4;
    localparam int SAT        = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_memHzd = 0, id_branchHzd = 0, id_cntlHzd = 0, id_hlt = 0;
    logic wb_hlt = 0, icache_rdy = 1, dcache_req = 0, dcache_rdy = 1;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, halted;
    logic [CNT_W-1:0] stall_cycles;

    pipeline_stall_ctrl #(.CNTL_DELAY(CNTL_DELAY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_memHzd(id_memHzd), .id_branchHzd(id_branchHzd), .id_cntlHzd(id_cntlHzd),
        .id_hlt(id_hlt), .wb_hlt(wb_hlt), .icache_rdy(icache_rdy),
        .dcache_req(dcache_req), .dcache_rdy(dcache_rdy),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ctl;   // {pc,ifid,flush,idex,bubble,exmem,memwb,halted}
        int         stall;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;

    // Reference model: -1 means no control instruction outstanding, otherwise
    // the number of cycles still to wait before the resolved PC may load.
    int m_wait, m_stall;
    bit m_drain, m_halt;
    int nx_wait, nx_stall;
    bit nx_drain, nx_halt;

    task automatic model_reset();
        m_wait = -1; m_stall = 0; m_drain = 0; m_halt = 0;
    endtask

    task automatic model_eval(output logic [7:0] ctl);
        bit pc = 1, ifd = 1, fl = 0, idx = 1, bub = 0, exm = 1, mwb = 1;
        nx_wait = m_wait; nx_stall = m_stall; nx_drain = m_drain; nx_halt = m_halt;
        if (m_halt || (dcache_req && !dcache_rdy)) begin
            pc = 0; ifd = 0; idx = 0; exm = 0; mwb = 0;
        end else begin
            if (m_drain) begin
                pc = 0; fl = 1; bub = 1;
            end else if (m_wait >= 0) begin
                fl = 1; bub = 1;
                if (m_wait > 0) begin
                    pc = 0; nx_wait = m_wait - 1;
                end else if (icache_rdy) nx_wait = -1;
                else pc = 0;
            end else if (id_memHzd || id_branchHzd) begin
                pc = 0; ifd = 0; bub = 1;
            end else if (id_cntlHzd) begin
                pc = 0; fl = 1;
                if (id_hlt) nx_drain = 1;
                else nx_wait = CNTL_DELAY - 1;
            end else if (!icache_rdy) begin
                pc = 0; fl = 1;
            end
            if (wb_hlt) begin
                nx_halt = 1; nx_drain = 0; nx_wait = -1;
            end
        end
        if (!pc && !m_halt && m_stall < SAT) nx_stall = m_stall + 1;
        ctl = {pc, ifd, fl, idx, bub, exm, mwb, m_halt};
    endtask

    // One clock: drive inputs, predict this cycle's outputs, then advance.
    task automatic cyc(input bit mh, input bit bh, input bit ch, input bit hl,
                       input bit wh, input bit ic, input bit dq, input bit dr);
        exp_t e;
        logic [7:0] ctl;
        id_memHzd = mh; id_branchHzd = bh; id_cntlHzd = ch; id_hlt = hl;
        wb_hlt = wh; icache_rdy = ic; dcache_req = dq; dcache_rdy = dr;
        model_eval(ctl);
        e.ctl = ctl; e.stall = m_stall; e.cyc = cyc_no;
        exp_q.push_back(e);
        @(posedge clk); #1;
        cyc_no++;
        if (rst_n) begin
            m_wait = nx_wait; m_stall = nx_stall; m_drain = nx_drain; m_halt = nx_halt;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1);
    endtask

    task automatic check_direct(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc_no, act, req);
        end
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from both clock edges.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check_direct("rst_halted", int'(halted), 0);
        check_direct("rst_stall", int'(stall_cycles), 0);
        model_reset();
        idle(1);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents outputs, compare with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, halted} != e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl cycle %0d: got %b, expected %b", e.cyc,
                             {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, halted}, e.ctl);
                end
                n_tests++;
                if (int'(stall_cycles) != e.stall) begin
                    n_fail++;
                    $display("FAIL stall_cycles cycle %0d: got %0d, expected %0d", e.cyc, stall_cycles, e.stall);
                end
            end
        end
    end

    initial begin
        int hold;
        bit ch, wh;
        model_reset();
        #13 rst_n = 1'b1;
        @(posedge clk); #1;

        // Load-use stall
        cyc(1, 0, 0, 0, 0, 1, 0, 1);
        idle(2);
        check_direct("loaduse_stall", int'(stall_cycles), 1);

        // Branch, then branch with I-cache miss at resolve
        cyc(0, 0, 1, 0, 0, 1, 0, 1);
        idle(3);
        check_direct("branch_stall", int'(stall_cycles), 3);
        cyc(0, 0, 1, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        check_direct("branch_miss_stall", int'(stall_cycles), 8);

        // D-cache freeze inside the control wait
        cyc(0, 0, 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 1, 0);
        idle(3);
        async_reset();

        // Halt drain, then frozen for 20 cycles
        cyc(0, 0, 1, 1, 0, 1, 0, 1);
        idle(2);
        cyc(0, 0, 0, 0, 1, 1, 0, 1);
        for (int i = 0; i < 20; i++) cyc(1, 0, 1, 0, 0, 0, 1, 0);
        check_direct("halt_flag", int'(halted), 1);
        check_direct("halt_stall_frozen", int'(stall_cycles), 4);
        async_reset();

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 1, 0, 1);
        check_direct("stall_saturated", int'(stall_cycles), SAT);
        async_reset();

        // Randomized traffic with periodic resets
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            ch = ($urandom_range(7) == 0);
            wh = m_drain ? ($urandom_range(3) == 0) : ($urandom_range(299) == 0);
            cyc($urandom_range(7) == 0, $urandom_range(9) == 0, ch,
                ch && ($urandom_range(3) == 0), wh, $urandom_range(3) != 0,
                $urandom_range(3) == 0, $urandom_range(1) == 0);
            hold = m_halt ? hold + 1 : 0;
            if (hold > 6 || $urandom_range(249) == 0) begin
                async_reset();
                hold = 0;
            end
        end

        idle(1);
        @(negedge clk); #1;
        check_direct("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
